// File: rtl/bf_tape_ctrl.sv
// bf_tape_ctrl: data-tape controller for the Brainfuck execution core.
// Holds DEPTH cells of CELL_W bits. Accepts one command per clock while
// READY, and sweeps the whole array to zero after reset or a CLEAR command.
//
// Ports:
//   working_clock  sole clock, rising edge
//   reset          synchronous, active-high
//   cmd_valid      command present this cycle
//   cmd_op         0 NOP, 1 INC, 2 DEC, 3 SET, 4 RIGHT, 5 LEFT, 6 REWIND, 7 CLEAR
//   cmd_data       value for SET
//   available      high in READY; a command is taken iff cmd_valid && available
//   tape_symbol    cell[tape_ptr], forced to 0 while not available
//   tape_zero      tape_symbol == 0
//   tape_ptr       current pointer
//   ptr_fault      sticky flag for an attempted move past an end (WRAP_PTR=0)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweep: one cell zeroed per edge, commands ignored
// ST_READY | commands accepted, one cell written at most per edge
module bf_tape_ctrl #(
   parameter int CELL_W   = 8,
   parameter int DEPTH    = 256,
   parameter int PTR_W    = 8,
   parameter int WRAP_PTR = 0
) (
   input  logic              working_clock,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [2:0]        cmd_op,
   input  logic [CELL_W-1:0] cmd_data,
   output logic              available,
   output logic [CELL_W-1:0] tape_symbol,
   output logic              tape_zero,
   output logic [PTR_W-1:0]  tape_ptr,
   output logic              ptr_fault
);

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_INC    = 3'd1;
   localparam logic [2:0] OP_DEC    = 3'd2;
   localparam logic [2:0] OP_SET    = 3'd3;
   localparam logic [2:0] OP_RIGHT  = 3'd4;
   localparam logic [2:0] OP_LEFT   = 3'd5;
   localparam logic [2:0] OP_REWIND = 3'd6;
   localparam logic [2:0] OP_CLEAR  = 3'd7;

   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'b00,
      ST_READY = 2'b01
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  idx_q, idx_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              fault_q, fault_d;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_addr;
   logic [CELL_W-1:0] wr_data;
   logic [CELL_W-1:0] cur_cell;
   logic [CELL_W-1:0] cells [DEPTH];

   assign cur_cell = cells[ptr_q];

   always_ff @(posedge working_clock) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         idx_q   <= '0;
         ptr_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         fault_q <= fault_d;
      end
   end

   // The array has no reset of its own; the sweep is what zeroes it. Reset
   // still blocks the write so a command coincident with reset is dropped.
   always_ff @(posedge working_clock) begin
      if (!reset && wr_en) begin
         cells[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      fault_d = fault_q;
      wr_en   = 1'b0;
      wr_addr = ptr_q;
      wr_data = cur_cell;
      case (state_q)
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = '0;
            idx_d   = idx_q + 1'b1;
            if (idx_q == PTR_MAX) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_INC: begin
                     wr_en   = 1'b1;
                     wr_data = cur_cell + 1'b1;
                  end
                  OP_DEC: begin
                     wr_en   = 1'b1;
                     wr_data = cur_cell - 1'b1;
                  end
                  OP_SET: begin
                     wr_en   = 1'b1;
                     wr_data = cmd_data;
                  end
                  OP_RIGHT: begin
                     if (ptr_q != PTR_MAX) begin
                        ptr_d = ptr_q + 1'b1;
                     end else if (WRAP_PTR != 0) begin
                        ptr_d = '0;
                     end else begin
                        fault_d = 1'b1;
                     end
                  end
                  OP_LEFT: begin
                     if (ptr_q != '0) begin
                        ptr_d = ptr_q - 1'b1;
                     end else if (WRAP_PTR != 0) begin
                        ptr_d = PTR_MAX;
                     end else begin
                        fault_d = 1'b1;
                     end
                  end
                  OP_REWIND: ptr_d = '0;
                  OP_CLEAR: begin
                     ptr_d   = '0;
                     fault_d = 1'b0;
                     idx_d   = '0;
                     state_d = ST_CLEAR;
                  end
                  default: ;
               endcase
            end
         end
         default: begin
            state_d = ST_CLEAR;
            idx_d   = '0;
         end
      endcase
   end

   assign available   = (state_q == ST_READY);
   assign tape_symbol = available ? cur_cell : '0;
   assign tape_zero   = (tape_symbol == '0);
   assign tape_ptr    = ptr_q;
   assign ptr_fault   = fault_q;

endmodule

// File: doc/bf_tape_ctrl.md
# bf_tape_ctrl

Parametrised data-tape controller for the Brainfuck execution core, successor to the fixed 128-cell/4-bit tape. Holds DEPTH cells of CELL_W bits in a register array, accepts one single-cycle command per clock (inc, dec, set, move, rewind, clear), and exposes the current cell, a zero flag and the pointer to the instruction sequencer. Clearing is a multi-cycle sweep that runs after reset and on request, with `available` deasserted while it runs. Pointer edge behaviour (saturate or wrap) is selectable.

## Interface
- CELL_W, 8, cell width in bits (≥1)
- DEPTH, 256, number of cells (≥2, power of two)
- PTR_W, 8, pointer width, must equal log2(DEPTH)
- WRAP_PTR, 0, 0 = pointer saturates at ends and flags fault; 1 = pointer wraps modulo DEPTH

- working_clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- cmd_valid  in  1  command present this cycle
- cmd_op  in  3  0 NOP, 1 INC, 2 DEC, 3 SET, 4 RIGHT, 5 LEFT, 6 REWIND, 7 CLEAR
- cmd_data  in  CELL_W  value for SET; ignored otherwise
- available  out  1  high when in READY; command accepted iff cmd_valid && available
- tape_symbol  out  CELL_W  cell[tape_ptr]; forced 0 while available=0
- tape_zero  out  1  tape_symbol == 0
- tape_ptr  out  PTR_W  current pointer
- ptr_fault  out  1  sticky: a saturated move was attempted (WRAP_PTR=0 only)

## Operation
- States: CLEAR (sweep) and READY. 2-bit or 1-bit state register; unused encodings go to CLEAR.
- Reset (sampled high at an edge): state=CLEAR, sweep index=0, tape_ptr=0, ptr_fault=0, available=0. Array contents are not reset directly; the sweep zeroes them.
- CLEAR: each edge writes 0 to cell[index], index+1. The edge that clears cell[DEPTH-1] moves to READY. cmd_valid ignored (not queued, not stored).
- READY, accepted command:
  - INC/DEC: cell[ptr] ± 1, modulo 2^CELL_W (255+1=0, 0-1=255 for CELL_W=8).
  - SET: cell[ptr] = cmd_data.
  - RIGHT: ptr+1. At DEPTH-1: WRAP_PTR=1 → 0; WRAP_PTR=0 → ptr unchanged, ptr_fault←1.
  - LEFT: ptr-1. At 0: WRAP_PTR=1 → DEPTH-1; WRAP_PTR=0 → unchanged, ptr_fault←1.
  - REWIND: ptr=0, cells untouched.
  - CLEAR: ptr=0, ptr_fault=0, index=0, state=CLEAR, available falls next edge.
  - NOP: no change.
- Only one cell written per cycle; ops are mutually exclusive by encoding.
- ptr_fault cleared only by reset or CLEAR op.

## Timing
- All outputs registered-state driven; tape_symbol/tape_zero are a combinational read of the array at tape_ptr, so an accepted command is visible on outputs the cycle after its edge.
- Command latency: 1 edge. Throughput: 1 command/cycle, back-to-back INC/move legal.
- Clear sweep: available low for exactly DEPTH cycles after reset deasserts (or after the CLEAR-op edge), rising on the DEPTH-th edge.
- Reset asserted mid-sweep restarts sweep from index 0; reset asserted during READY discards any concurrent command.
- Reset dominates cmd_valid at the same edge.

## Test plan
- DEPTH=8, CELL_W=8: release reset → available=0 for 8 cycles, then 1; tape_symbol=0, tape_zero=1, tape_ptr=0.
- SET 0xFE, INC, INC, DEC back-to-back at ptr 0 → tape_symbol 0xFE, 0xFF, 0x00 (tape_zero=1), 0xFF on successive cycles.
- WRAP_PTR=0: LEFT at ptr 0 → ptr stays 0, ptr_fault=1; 9 RIGHTs → ptr saturates at 7, fault stays 1. WRAP_PTR=1: LEFT at 0 → ptr=7, fault stays 0.
- SET cell2=0x11, cell5=0x22, REWIND → ptr=0, cell2/cell5 retain values on re-visit; CLEAR op → available low 8 cycles, all cells read 0, ptr_fault=0.
- Commands with cmd_valid=1 during sweep → no cell or ptr change after available rises.
- Assert reset at sweep index 4, hold 1 cycle → available low for a fresh 8 cycles; reset coincident with SET in READY → cell unchanged (cleared by sweep).
